// File: rtl/clock_pkg.sv
// Shared constants and small helpers for the desktop clock's time-setting path.
// Unit limits are passed into MAX_VAL by each value-setter instance.
package clock_pkg;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;
    localparam int VAL_W    = 6;

    typedef logic [VAL_W-1:0] val_t;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

    // Clamp an externally supplied value into 0..max_v.
    function automatic val_t sat_val(input val_t v, input val_t max_v);
        return (v > max_v) ? max_v : v;
    endfunction

    function automatic val_t step_val(input val_t v, input val_t max_v, input dir_e dir);
        if (dir == DIR_UP) begin
            return (v == max_v) ? '0 : v + val_t'(1);
        end
        return (v == '0) ? max_v : v - val_t'(1);
    endfunction

endpackage

// File: rtl/debounce.sv
// Two-flop synchronizer followed by a counter debouncer for one raw button.
// The output level flips only after DEBOUNCE_CYC consecutive cycles of disagreement.
module debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          w_differs;

    assign w_differs = (r_sync2 != r_level);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (!w_differs) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/btn_value_set.sv
// Button-driven 6-bit wrapping value setter: debounced up/down buttons with
// hold-to-repeat, plus a saturating load port that overrides button steps.
module btn_value_set
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int HOLD_CYC     = 50_000_000,
    parameter int REPEAT_CYC   = 10_000_000,
    parameter int MAX_VAL      = SEC_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up,
    input  logic             btn_dn,
    input  logic             en,
    input  logic             load,
    input  logic [VAL_W-1:0] load_val,
    output logic [VAL_W-1:0] val,
    output logic             step
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PRESS  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    localparam int CNT_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
    localparam val_t MAX_V = val_t'(MAX_VAL);

    logic             w_up;
    logic             w_dn;
    logic             w_press_up;
    logic             w_press_dn;
    logic             w_valid;
    dir_e             w_dir;
    logic             w_match;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    dir_e             r_dir;
    val_t             r_val;
    logic             r_step;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    dir_e             w_dir_nxt;
    logic             w_step_req;
    dir_e             w_step_dir;

    debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (btn_up),
        .o_level (w_up)
    );

    debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dn (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (btn_dn),
        .o_level (w_dn)
    );

    assign w_press_up = w_up & ~w_dn;
    assign w_press_dn = w_dn & ~w_up;
    assign w_valid    = w_press_up | w_press_dn;
    assign w_dir      = w_press_dn ? DIR_DN : DIR_UP;
    // Leaving the latched direction (release, both held, swap) always drops to IDLE.
    assign w_match    = (r_dir == DIR_UP) ? w_press_up : w_press_dn;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_step_req  = 1'b0;
        w_step_dir  = r_dir;
        if (!en) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        w_state_nxt = ST_PRESS;
                        w_dir_nxt   = w_dir;
                        w_cnt_nxt   = '0;
                        w_step_req  = 1'b1;
                        w_step_dir  = w_dir;
                    end
                end
                ST_PRESS: begin
                    if (!w_match) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == HOLD_LAST) begin
                        w_state_nxt = ST_REPEAT;
                        w_cnt_nxt   = '0;
                        w_step_req  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (!w_match) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == REP_LAST) begin
                        w_cnt_nxt  = '0;
                        w_step_req = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_dir   <= DIR_UP;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    // Load wins over a same-cycle step; the FSM still advances untouched.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_val  <= '0;
            r_step <= 1'b0;
        end else if (load) begin
            r_val  <= sat_val(load_val, MAX_V);
            r_step <= 1'b0;
        end else if (w_step_req) begin
            r_val  <= step_val(r_val, MAX_V, w_step_dir);
            r_step <= 1'b1;
        end else begin
            r_step <= 1'b0;
        end
    end

    assign val  = r_val;
    assign step = r_step;

endmodule

// File: tb/tb_btn_value_set.sv
// Directed self-checking bench for btn_value_set with short debounce/hold/repeat
// intervals; expected step edges are counted from the cycle a button is driven.
module tb_btn_value_set;

    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;
    localparam int MAXV = 59;

    logic       clk;
    logic       rst;
    logic       btn_up;
    logic       btn_dn;
    logic       en;
    logic       load;
    logic [5:0] load_val;
    logic [5:0] val;
    logic       step;

    int n_checks;
    int n_fail;
    int edge_no;
    int step_cnt;
    int step_edges[$];

    btn_value_set #(
        .DEBOUNCE_CYC (DEB),
        .HOLD_CYC     (HOLD),
        .REPEAT_CYC   (REP),
        .MAX_VAL      (MAXV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_up   (btn_up),
        .btn_dn   (btn_dn),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .val      (val),
        .step     (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Advance n rising edges, sampling 1 ns after each and logging step pulses.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            edge_no++;
            if (step) begin
                step_cnt++;
                step_edges.push_back(edge_no);
            end
        end
    endtask

    task automatic mark();
        edge_no  = 0;
        step_cnt = 0;
        step_edges.delete();
    endtask

    function automatic int step_at(input int idx);
        return (idx < step_edges.size()) ? step_edges[idx] : -1;
    endfunction

    task automatic do_load(input logic [5:0] v);
        load     = 1'b1;
        load_val = v;
        cyc(1);
        load     = 1'b0;
        load_val = '0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        btn_up   = 1'b0;
        btn_dn   = 1'b0;
        en       = 1'b1;
        load     = 1'b0;
        load_val = '0;
        mark();
        cyc(3);
        check("reset_val", int'(val), 0);
        check("reset_step", int'(step), 0);
        rst = 1'b1;
        cyc(2);

        // Bounce rejection: 1-cycle high / 1-cycle low for 20 cycles.
        mark();
        for (int i = 0; i < 20; i++) begin
            btn_up = (i % 2 == 0);
            cyc(1);
        end
        btn_up = 1'b0;
        cyc(12);
        check("bounce_steps", step_cnt, 0);
        check("bounce_val", int'(val), 0);

        // Single press held for 8 cycles.
        mark();
        btn_up = 1'b1;
        cyc(8);
        btn_up = 1'b0;
        check("single_step_edge", step_at(0), 7);
        check("single_val", int'(val), 1);
        cyc(12);
        check("single_step_cnt", step_cnt, 1);

        // Wrap up from MAX and down from 0.
        do_load(6'd59);
        check("load_59", int'(val), 59);
        mark();
        btn_up = 1'b1;
        cyc(8);
        btn_up = 1'b0;
        cyc(12);
        check("wrap_up_val", int'(val), 0);
        check("wrap_up_steps", step_cnt, 1);
        mark();
        btn_dn = 1'b1;
        cyc(8);
        btn_dn = 1'b0;
        cyc(12);
        check("wrap_dn_val", int'(val), 59);
        check("wrap_dn_steps", step_cnt, 1);

        // Auto-repeat down from 5.
        do_load(6'd5);
        mark();
        btn_dn = 1'b1;
        cyc(24);
        check("rep_step0", step_at(0), 7);
        check("rep_step1", step_at(1), 17);
        check("rep_step2", step_at(2), 20);
        check("rep_step3", step_at(3), 23);
        check("rep_val_e23", int'(val), 1);
        // Raw release after edge 24: repeats at 26 and 29 precede IDLE at edge 31.
        btn_dn = 1'b0;
        cyc(7);
        check("rep_rel_steps", step_cnt, 6);
        check("rep_rel_last", step_at(5), 29);
        check("rep_rel_val", int'(val), 59);
        cyc(15);
        check("rep_after_idle", step_cnt, 6);

        // Both buttons held together.
        do_load(6'd10);
        mark();
        btn_up = 1'b1;
        btn_dn = 1'b1;
        cyc(20);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        cyc(12);
        check("both_steps", step_cnt, 0);
        check("both_val", int'(val), 10);

        // Saturating load.
        do_load(6'd63);
        check("sat_val", int'(val), 59);
        check("sat_step", int'(step), 0);

        // Load coincides with the first step at edge 7.
        do_load(6'd20);
        mark();
        btn_up = 1'b1;
        cyc(6);
        load     = 1'b1;
        load_val = 6'd33;
        cyc(1);
        load     = 1'b0;
        load_val = '0;
        check("ld_coll_val", int'(val), 33);
        check("ld_coll_step", int'(step), 0);
        cyc(1);
        btn_up = 1'b0;
        cyc(12);
        check("ld_coll_steps", step_cnt, 0);
        check("ld_coll_final", int'(val), 33);

        // Disabled: held button does nothing.
        en = 1'b0;
        mark();
        btn_up = 1'b1;
        cyc(20);
        btn_up = 1'b0;
        cyc(12);
        check("en0_steps", step_cnt, 0);
        check("en0_val", int'(val), 33);
        en = 1'b1;
        cyc(2);

        // Reset during REPEAT at val=30, button kept held.
        do_load(6'd28);
        mark();
        btn_up = 1'b1;
        cyc(18);
        check("mid_pre_val", int'(val), 30);
        rst = 1'b0;
        cyc(1);
        check("mid_rst_val", int'(val), 0);
        check("mid_rst_step", int'(step), 0);
        rst = 1'b1;
        mark();
        cyc(8);
        check("mid_post_edge", step_at(0), 7);
        check("mid_post_val", int'(val), 1);
        check("mid_post_cnt", step_cnt, 1);
        btn_up = 1'b0;
        cyc(15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
